// File: rtl/mam_defs_pkg.sv
// Shared definitions for the memory access monitor: permission bit indices,
// FSM state encoding and the 17-bit inclusive range-check helper.
package mam_defs_pkg;

  localparam int unsigned T_RD = 0;
  localparam int unsigned T_WR = 1;
  localparam int unsigned U_RD = 2;
  localparam int unsigned U_WR = 3;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  // Inclusive [base, base+size-1] in 17 bits so a region ending at 16'hFFFF
  // cannot wrap; size 0 is an empty region.
  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] size);
    logic [16:0] a;
    logic [16:0] lo;
    logic [16:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size} - 17'd1;
    return (size != 16'h0000) && (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mam_region_chk.sv
// Per-region access check: address hit, trusted write allowance and
// permission violation for the current data access.
module mam_region_chk
  import mam_defs_pkg::*;
#(
  parameter logic [15:0] BASE = 16'h0000,
  parameter logic [15:0] SIZE = 16'h0000,
  parameter logic [3:0]  PERM = 4'b0000
) (
  input  logic [15:0] addr,
  input  logic        r_en,
  input  logic        w_en,
  input  logic        trusted,
  output logic        hit,
  output logic        t_wr_ok,
  output logic        viol
);

  logic rd_ok;
  logic wr_ok;

  always_comb begin
    hit     = in_range(addr, BASE, SIZE);
    rd_ok   = trusted ? PERM[T_RD] : PERM[U_RD];
    wr_ok   = trusted ? PERM[T_WR] : PERM[U_WR];
    t_wr_ok = hit & PERM[T_WR];
    viol    = hit & ((r_en & ~rd_ok) | (w_en & ~wr_ok));
  end

endmodule

// File: rtl/mem_access_monitor.sv
// Data access monitor: checks accesses against NREG permission regions,
// requests a sticky core reset on violation and captures the first cause.
module mem_access_monitor
  import mam_defs_pkg::*;
#(
  parameter int unsigned      NREG            = 4,
  parameter logic [15:0]      TCODE_BASE      = 16'hA000,
  parameter logic [15:0]      TCODE_SIZE      = 16'h4000,
  parameter logic [16*NREG-1:0] REG_BASE      = {16'hFEFE, 16'h9000, 16'h8000, 16'h0400},
  parameter logic [16*NREG-1:0] REG_SIZE      = {16'h0040, 16'h001F, 16'h0020, 16'h0C00},
  parameter logic [4*NREG-1:0]  REG_PERM      = {4'b0001, 4'b0111, 4'b1111, 4'b0011},
  parameter bit               TRUSTED_WR_CONF = 1'b1,
  parameter logic [15:0]      RESET_HANDLER   = 16'hFFFE,
  parameter int unsigned      KILL_MIN        = 4,
  parameter int unsigned      CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      pc,
  input  logic [15:0]      data_addr,
  input  logic             r_en,
  input  logic             w_en,
  output logic             reset,
  output logic [NREG:0]    viol_cause,
  output logic [15:0]      viol_addr,
  output logic [15:0]      viol_pc,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int unsigned HW = (KILL_MIN > 1) ? $clog2(KILL_MIN) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(KILL_MIN - 1);

  state_t        state;
  state_t        next_state;
  logic [HW-1:0] hold_cnt;

  logic            trusted;
  logic [NREG-1:0] hit;
  logic [NREG-1:0] t_wr_ok;
  logic [NREG-1:0] viol;
  logic            stray;
  logic            violation;
  logic            release_ok;

  // Trusted iff BASE <= pc <= BASE+SIZE-2, written as pc+2 <= BASE+SIZE to stay unsigned.
  always_comb begin
    trusted = ({1'b0, pc} >= {1'b0, TCODE_BASE}) &&
              ({1'b0, pc} + 17'd2 <= {1'b0, TCODE_BASE} + {1'b0, TCODE_SIZE});
  end

  for (genvar g = 0; g < NREG; g++) begin : g_region
    mam_region_chk #(
      .BASE(REG_BASE[16*g +: 16]),
      .SIZE(REG_SIZE[16*g +: 16]),
      .PERM(REG_PERM[4*g +: 4])
    ) u_chk (
      .addr   (data_addr),
      .r_en   (r_en),
      .w_en   (w_en),
      .trusted(trusted),
      .hit    (hit[g]),
      .t_wr_ok(t_wr_ok[g]),
      .viol   (viol[g])
    );
  end

  always_comb begin
    stray      = TRUSTED_WR_CONF & trusted & w_en & ~(|t_wr_ok);
    violation  = (|viol) | stray;
    release_ok = (hold_cnt >= HOLD_MAX) && (pc == RESET_HANDLER) && !violation;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (violation)  next_state = KILL;
      KILL:    if (release_ok) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      hold_cnt   <= '0;
      viol_cause <= '0;
      viol_addr  <= '0;
      viol_pc    <= '0;
      viol_cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == RUN && violation) begin
        hold_cnt   <= '0;
        viol_cause <= {stray, viol};
        viol_addr  <= data_addr;
        viol_pc    <= pc;
        if (viol_cnt != '1) viol_cnt <= viol_cnt + CNT_W'(1);
      end else if (state == KILL && hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  assign reset = (state == KILL);

endmodule

// File: tb/tb_mem_access_monitor.sv
// Directed self-checking bench for mem_access_monitor with default parameters.
module tb_mem_access_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic [15:0] data_addr;
  logic        r_en;
  logic        w_en;
  logic        reset;
  logic [4:0]  viol_cause;
  logic [15:0] viol_addr;
  logic [15:0] viol_pc;
  logic [7:0]  viol_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .data_addr (data_addr),
    .r_en      (r_en),
    .w_en      (w_en),
    .reset     (reset),
    .viol_cause(viol_cause),
    .viol_addr (viol_addr),
    .viol_pc   (viol_pc),
    .viol_cnt  (viol_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] p, input logic [15:0] a, input logic r, input logic w);
    pc = p; data_addr = a; r_en = r; w_en = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(16'h5000, 16'h0000, 1'b0, 1'b0);
  endtask

  // Starting on the first KILL cycle: three quiet cycles, then the handler PC.
  task automatic release_kill();
    idle(); step(); step(); step();
    drive(16'hFFFE, 16'h0000, 1'b0, 1'b0); step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) step();
    check("rst_reset", 32'(reset), 32'h0);
    check("rst_cause", 32'(viol_cause), 32'h0);
    check("rst_cnt", 32'(viol_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    check("idle_reset", 32'(reset), 32'h0);

    // Untrusted read of SDATA
    drive(16'h5000, 16'h0500, 1'b1, 1'b0); step();
    check("t1_reset", 32'(reset), 32'h1);
    check("t1_cause", 32'(viol_cause), 32'h01);
    check("t1_addr", 32'(viol_addr), 32'h0500);
    check("t1_pc", 32'(viol_pc), 32'h5000);
    check("t1_cnt", 32'(viol_cnt), 32'h1);

    // Handler PC too early, then on the 4th KILL cycle
    idle(); step();
    drive(16'hFFFE, 16'h0000, 1'b0, 1'b0); step();
    check("t4_early", 32'(reset), 32'h1);
    idle(); step();
    drive(16'hFFFE, 16'h0000, 1'b0, 1'b0); step();
    check("t4_release", 32'(reset), 32'h0);
    idle();

    // Trusted stray write, then trusted write to HMAC
    drive(16'hA100, 16'h2000, 1'b0, 1'b1); step();
    check("t2_reset", 32'(reset), 32'h1);
    check("t2_cause", 32'(viol_cause), 32'h10);
    check("t2_cnt", 32'(viol_cnt), 32'h2);
    release_kill();
    check("t2_rel", 32'(reset), 32'h0);
    drive(16'hA100, 16'h8010, 1'b0, 1'b1); step();
    check("t2_hmac_ok", 32'(reset), 32'h0);

    // CTR: untrusted read allowed, write not
    drive(16'h5000, 16'h9005, 1'b1, 1'b0); step();
    check("t3_rd_ok", 32'(reset), 32'h0);
    drive(16'h5000, 16'h9005, 1'b0, 1'b1); step();
    check("t3_reset", 32'(reset), 32'h1);
    check("t3_cause", 32'(viol_cause), 32'h04);
    check("t3_cnt", 32'(viol_cnt), 32'h3);
    release_kill();

    // Trusted window and region edges
    drive(16'hDFFE, 16'hFEFE, 1'b1, 1'b0); step();
    check("b_tr_top", 32'(reset), 32'h0);
    drive(16'hA000, 16'h0500, 1'b1, 1'b1); step();
    check("b_tr_base_rw", 32'(reset), 32'h0);
    drive(16'h5000, 16'hFF3E, 1'b1, 1'b0); step();
    check("b_kmem_past", 32'(reset), 32'h0);
    drive(16'h5000, 16'h9FFF, 1'b0, 1'b0); step();
    check("b_nostrobe", 32'(reset), 32'h0);
    drive(16'hDFFF, 16'hFF3D, 1'b1, 1'b0); step();
    check("b_untr_kmem", 32'(reset), 32'h1);
    check("b_cause", 32'(viol_cause), 32'h08);
    check("b_addr", 32'(viol_addr), 32'hFF3D);
    check("b_pc", 32'(viol_pc), 32'hDFFF);
    check("b_cnt", 32'(viol_cnt), 32'h4);

    // Violations inside KILL, including one at release time
    drive(16'h5000, 16'h9005, 1'b0, 1'b1); step();
    idle(); step(); step();
    drive(16'hFFFE, 16'h0500, 1'b1, 1'b0); step();
    check("t5_stay", 32'(reset), 32'h1);
    check("t5_cause", 32'(viol_cause), 32'h08);
    check("t5_addr", 32'(viol_addr), 32'hFF3D);
    check("t5_cnt", 32'(viol_cnt), 32'h4);
    drive(16'hFFFE, 16'h0000, 1'b0, 1'b0); step();
    check("t5_release", 32'(reset), 32'h0);

    // Async reset mid-KILL
    drive(16'h5000, 16'h0500, 1'b1, 1'b0); step();
    check("t6_kill", 32'(reset), 32'h1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'(reset), 32'h0);
    check("t6_async_cause", 32'(viol_cause), 32'h0);
    check("t6_async_addr", 32'(viol_addr), 32'h0);
    check("t6_async_cnt", 32'(viol_cnt), 32'h0);
    #1 rst_n = 1'b1;
    step();

    // Counter saturation
    for (int i = 0; i < 255; i++) begin
      drive(16'h5000, 16'h0500, 1'b1, 1'b0); step();
      release_kill();
    end
    check("sat_255", 32'(viol_cnt), 32'hFF);
    drive(16'h5000, 16'h0500, 1'b1, 1'b0); step();
    check("sat_hold", 32'(viol_cnt), 32'hFF);
    check("sat_kill", 32'(reset), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
